fifo_pack_reader: RTL and testbench
===================================

// Module: fifo_pack_reader
// PURPOSE
//   Read-side consumer for the push/pop FIFOs (srFIFO/rbFIFO interface).
//   - Pops items from the FIFO and packs NPACK consecutive items into one wide word.
//   - Delivers each word downstream over a valid/ready handshake.
//   - A flush request emits a partial word.
//   - Models the pop-side protocol, including the rule that push wins over pop.
// PARAMETERS
//   MSBD   3   MSB index of one FIFO item (item width MSBD+1)
//   NPACK  4   items per output word; must be >= 2
//   CNTW   3   width of count fields; 2**CNTW > NPACK
// PORTS
//   clock      in   1               rising-edge clock
//   reset      in   1               synchronous, active-high
//   fifo_data  in   MSBD+1          FIFO head item; valid when fifo_empty=0
//   fifo_empty in   1               FIFO empty flag
//   fifo_full  in   1               FIFO full flag
//   fifo_push  in   1               writer's push request this cycle
//   fifo_pop   out  1               pop request to FIFO
//   flush      in   1               emit partial word (one-cycle pulse or level)
//   out_data   out  NPACK*(MSBD+1)  packed word; lane k = bits [k*(MSBD+1)+:MSBD+1]
//   out_count  out  CNTW            number of valid lanes in out_data (1..NPACK)
//   out_valid  out  1               out_data/out_count valid
//   out_ready  in   1               downstream accepts word
//   busy       out  1               acc_cnt!=0 | out_valid | flush_pend
// BEHAVIOUR
//   Internal state
//   - acc[NPACK lanes], acc_cnt (0..NPACK), flush_pend.
//   - Output register: out_data, out_count, out_valid.
//   Reset (sync, clock edge with reset=1)
//   - acc_cnt=0, flush_pend=0.
//   - out_valid=0, out_data=0, out_count=0.
//   - fifo_pop=0 combinationally while reset=1.
//   - Any partial or held word is discarded.
//   fifo_pop (combinational)
//   - fifo_pop = ~reset & ~fifo_empty & (acc_cnt<NPACK) & ~flush & ~flush_pend.
//   Effective pop
//   - pop_eff = fifo_pop & ~(fifo_push & ~fifo_full).
//   - A push accepted in the same cycle makes the FIFO ignore the pop.
//   - In that case nothing is captured, and the pop is retried next cycle.
//   Capture
//   - On pop_eff: acc[acc_cnt] <= fifo_data; acc_cnt += 1.
//   - The first popped item goes to lane 0 (LSBs).
//   Output slot
//   - slot_free = ~out_valid | out_ready.
//   - A word is consumed at any edge with out_valid & out_ready.
//   Full-word load
//   - Condition: (acc_cnt==NPACK) or (pop_eff & acc_cnt==NPACK-1), and slot_free.
//   - Action: out_data <= acc including the item captured this edge; out_count <= NPACK;
//     out_valid <= 1; acc_cnt <= 0.
//   - Latency: out_valid rises the cycle after the edge that captures the NPACK-th item.
//   - If the slot is not free, the full acc is held and fifo_pop stays 0 until the slot frees.
//   Flush
//   - flush=1 sets flush_pend and blocks pops starting that same cycle.
//   - When flush_pend & slot_free & acc_cnt>0: emit acc, unused lanes zero,
//     out_count=acc_cnt; acc_cnt <= 0; flush_pend <= 0.
//   - When flush_pend & acc_cnt==0: flush_pend <= 0 and no word is emitted (NOOP).
//   - A full acc takes the full-word path first; the pending flush then clears as a NOOP.
//   Output stability
//   - out_data/out_count hold while out_valid & ~out_ready.
//   - If not reloaded, out_valid drops after a consume.
//   - Back-to-back consume and load in the same edge is allowed (full throughput).
//   Ordering
//   - Items leave in exact FIFO pop order; no item is dropped or duplicated.
// TESTING (MSBD=3, NPACK=4)
//   1 reset; FIFO heads 1,2,3,4, out_ready=1 -> one cycle after 4th pop_eff:
//     out_valid=1, out_data=16'h4321, out_count=4.
//   2 out_ready=0, 8 items queued -> 16'h4321 held stable; acc fills 8,7,6,5; fifo_pop=0;
//     raise out_ready -> 16'h4321 then 16'h8765 on consecutive cycles.
//   3 fifo_push=1, fifo_full=0 in the cycle fifo_pop=1 -> no capture, acc_cnt unchanged;
//     final word still 16'h4321 with no duplicate.
//   4 pop items A,B; pulse flush -> out_data=16'h00BA, out_count=2;
//     second flush with acc_cnt=0 -> out_valid stays 0.
//   5 reset=1 with acc_cnt=3 and out_valid=1 -> next cycle out_valid=0, busy=0;
//     fifo_pop=0 during reset.
//   6 fifo_empty=1 for 10 cycles -> fifo_pop=0 throughout; acc_cnt unchanged.

Source files
------------

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: pops items from a push/pop FIFO, packs NPACK of them
// into one wide word (first item in lane 0) and hands the word downstream
// over a valid/ready handshake. A flush request emits whatever has been
// collected so far as a partial word with its unused lanes zeroed.
module fifo_pack_reader #(
   parameter int MSBD  = 3,
   parameter int NPACK = 4,
   parameter int CNTW  = 3
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [MSBD:0]             fifo_data,
   input  logic                      fifo_empty,
   input  logic                      fifo_full,
   input  logic                      fifo_push,
   output logic                      fifo_pop,
   input  logic                      flush,
   output logic [NPACK*(MSBD+1)-1:0] out_data,
   output logic [CNTW-1:0]           out_count,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy
);

   localparam int W = MSBD + 1;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NPACK);

   logic [NPACK*W-1:0] acc_q, acc_d;
   logic [CNTW-1:0]    acc_cnt_q, acc_cnt_d;
   logic               flush_pend_q, flush_pend_d;
   logic [NPACK*W-1:0] out_data_q, out_data_d;
   logic [CNTW-1:0]    out_count_q, out_count_d;
   logic               out_valid_q, out_valid_d;

   logic               pop_eff;
   logic               slot_free;
   logic               full_load;
   logic [NPACK*W-1:0] acc_cap;
   logic [NPACK*W-1:0] flush_word;
   logic [CNTW-1:0]    cnt_cap;

   // Pop request and the FIFO's view of it: a same-cycle accepted push wins.
   always_comb begin
      fifo_pop  = ~reset & ~fifo_empty & (acc_cnt_q < FULL_CNT) & ~flush & ~flush_pend_q;
      pop_eff   = fifo_pop & ~(fifo_push & ~fifo_full);
      slot_free = ~out_valid_q | out_ready;
   end

   // Accumulator as it would look after this edge's capture, plus the zero-padded flush word.
   always_comb begin
      acc_cap    = acc_q;
      flush_word = '0;
      for (int k = 0; k < NPACK; k++) begin
         if (pop_eff && (acc_cnt_q == CNTW'(k))) begin
            acc_cap[k*W +: W] = fifo_data;
         end
         if (CNTW'(k) < acc_cnt_q) begin
            flush_word[k*W +: W] = acc_q[k*W +: W];
         end
      end
      cnt_cap   = acc_cnt_q + {{(CNTW-1){1'b0}}, pop_eff};
      full_load = slot_free & (cnt_cap == FULL_CNT);
   end

   // Next-state: full words take priority over flush; flush with nothing collected is a no-op.
   always_comb begin
      acc_d        = acc_cap;
      acc_cnt_d    = cnt_cap;
      flush_pend_d = flush_pend_q;
      out_data_d   = out_data_q;
      out_count_d  = out_count_q;
      out_valid_d  = out_valid_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (full_load) begin
         out_data_d  = acc_cap;
         out_count_d = FULL_CNT;
         out_valid_d = 1'b1;
         acc_cnt_d   = '0;
      end else if (flush_pend_q && (acc_cnt_q == '0)) begin
         flush_pend_d = 1'b0;
      end else if (flush_pend_q && slot_free) begin
         out_data_d   = flush_word;
         out_count_d  = acc_cnt_q;
         out_valid_d  = 1'b1;
         acc_cnt_d    = '0;
         flush_pend_d = 1'b0;
      end
      if (flush) begin
         flush_pend_d = 1'b1;
      end
   end

   // State registers; reset discards any partial or held word.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q        <= '0;
         acc_cnt_q    <= '0;
         flush_pend_q <= 1'b0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         flush_pend_q <= flush_pend_d;
         out_data_q   <= out_data_d;
         out_count_q  <= out_count_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_valid = out_valid_q;
   assign busy      = (acc_cnt_q != '0) | out_valid_q | flush_pend_q;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// Testbench for fifo_pack_reader: a queue-based FIFO model feeds the DUT,
// stimulus pushes expected words onto a scoreboard, and a monitor pops and
// compares every word the DUT hands off.
module tb_fifo_pack_reader;

   logic        clock;
   logic        reset;
   logic [3:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_full;
   logic        fifo_push;
   logic        fifo_pop;
   logic        flush;
   logic [15:0] out_data;
   logic [2:0]  out_count;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   logic [3:0]  fifoQ[$];
   logic [18:0] expQ[$];
   logic [3:0]  pushVal;
   logic        doPop;
   logic        doPush;
   int          checkCount;
   int          passCount;

   fifo_pack_reader #(.MSBD(3), .NPACK(4), .CNTW(3)) dut (
      .clock(clock),
      .reset(reset),
      .fifo_data(fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_full(fifo_full),
      .fifo_push(fifo_push),
      .fifo_pop(fifo_pop),
      .flush(flush),
      .out_data(out_data),
      .out_count(out_count),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something never finishes
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic refreshFifo();
      fifo_empty = (fifoQ.size() == 0);
      fifo_data  = (fifoQ.size() != 0) ? fifoQ[0] : 4'h0;
   endtask

   // Load n items into the FIFO model, taken from the nibbles of items, lowest first
   task automatic applyStimulus(input int n, input logic [15:0] items);
      for (int i = 0; i < n; i++) begin
         fifoQ.push_back(items[i*4 +: 4]);
      end
      refreshFifo();
   endtask

   task automatic expectWord(input logic [2:0] cnt, input logic [15:0] data);
      expQ.push_back({cnt, data});
   endtask

   task automatic flushPulse();
      @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
   endtask

   task automatic waitIdle();
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < 60 && !idle; i++) begin
         @(negedge clock);
         #2;
         if (!busy && expQ.size() == 0) idle = 1'b1;
      end
      checkOutput("idle_timeout", {31'b0, idle}, 32'd1);
   endtask

   // FIFO model: the FIFO ignores a pop when a push is accepted in the same cycle
   always @(posedge clock) begin
      doPop  = fifo_pop && !(fifo_push && !fifo_full);
      doPush = fifo_push && !fifo_full;
      #1;
      if (doPop && fifoQ.size() != 0) void'(fifoQ.pop_front());
      if (doPush) fifoQ.push_back(pushVal);
      refreshFifo();
   end

   // Monitor: every handed-off word is compared against the scoreboard head
   always @(negedge clock) begin
      logic [18:0] exp;
      #1;
      if (!reset && out_valid && out_ready) begin
         checkOutput("word_expected", {31'b0, expQ.size() != 0}, 32'd1);
         if (expQ.size() != 0) begin
            exp = expQ.pop_front();
            checkOutput("word_data", {16'b0, out_data}, {16'b0, exp[15:0]});
            checkOutput("word_count", {29'b0, out_count}, {29'b0, exp[18:16]});
         end
      end
   end

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      fifo_full  = 1'b0;
      fifo_push  = 1'b0;
      pushVal    = 4'h0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      refreshFifo();

      // Reset state, with items waiting so a pop would otherwise be requested
      repeat (2) @(negedge clock);
      applyStimulus(4, 16'h4321);
      expectWord(3'd4, 16'h4321);
      #1;
      checkOutput("reset_pop", {31'b0, fifo_pop}, 32'd0);
      checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_data", {16'b0, out_data}, 32'd0);
      checkOutput("reset_count", {29'b0, out_count}, 32'd0);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);

      // Basic packing and latency: word appears right after the 4th capture edge
      @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("latency_early", {31'b0, out_valid}, 32'd0);
      @(negedge clock);
      checkOutput("latency_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("latency_data", {16'b0, out_data}, 32'h4321);
      waitIdle();

      // Backpressure: first word held, second fills acc, pop stalls with item 9 waiting
      @(negedge clock);
      out_ready = 1'b0;
      applyStimulus(4, 16'h4321);
      applyStimulus(4, 16'h8765);
      applyStimulus(1, 16'h0009);
      expectWord(3'd4, 16'h4321);
      expectWord(3'd4, 16'h8765);
      expectWord(3'd1, 16'h0009);
      repeat (12) @(negedge clock);
      #2;
      checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_data", {16'b0, out_data}, 32'h4321);
      checkOutput("hold_pop", {31'b0, fifo_pop}, 32'd0);
      @(negedge clock);
      checkOutput("hold_data_stable", {16'b0, out_data}, 32'h4321);
      out_ready = 1'b1;
      @(negedge clock);
      checkOutput("b2b_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("b2b_data", {16'b0, out_data}, 32'h8765);
      repeat (2) @(negedge clock);
      flushPulse();
      waitIdle();

      // Push wins over pop: the first pop is ignored and nothing is captured
      @(negedge clock);
      applyStimulus(4, 16'h4321);
      fifo_push = 1'b1;
      pushVal   = 4'h5;
      expectWord(3'd4, 16'h4321);
      expectWord(3'd1, 16'h0005);
      #1;
      checkOutput("collide_pop", {31'b0, fifo_pop}, 32'd1);
      @(negedge clock);
      fifo_push = 1'b0;
      #2;
      checkOutput("collide_no_capture", {31'b0, busy}, 32'd0);
      repeat (8) @(negedge clock);
      flushPulse();
      waitIdle();

      // Partial flush, then a flush with nothing collected
      @(negedge clock);
      applyStimulus(2, 16'h00BA);
      expectWord(3'd2, 16'h00BA);
      repeat (3) @(negedge clock);
      flushPulse();
      waitIdle();
      flushPulse();
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput("noop_flush_valid", {31'b0, out_valid}, 32'd0);
      end

      // Reset with a held word and a partial accumulator
      out_ready = 1'b0;
      applyStimulus(4, 16'h4321);
      applyStimulus(3, 16'h0765);
      repeat (10) @(negedge clock);
      checkOutput("pre_reset_valid", {31'b0, out_valid}, 32'd1);
      reset = 1'b1;
      applyStimulus(1, 16'h0009);
      #1;
      checkOutput("in_reset_pop", {31'b0, fifo_pop}, 32'd0);
      @(negedge clock);
      checkOutput("post_reset_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("post_reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("post_reset_pop", {31'b0, fifo_pop}, 32'd0);
      reset     = 1'b0;
      out_ready = 1'b1;
      expectWord(3'd1, 16'h0009);
      repeat (3) @(negedge clock);
      flushPulse();
      waitIdle();

      // Empty FIFO for 10 cycles with a partial accumulator
      @(negedge clock);
      applyStimulus(2, 16'h00DC);
      repeat (4) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         #1;
         checkOutput("empty_pop", {31'b0, fifo_pop}, 32'd0);
      end
      checkOutput("empty_busy", {31'b0, busy}, 32'd1);
      applyStimulus(2, 16'h00FE);
      expectWord(3'd4, 16'hFEDC);
      waitIdle();

      repeat (3) @(negedge clock);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
